// File: rtl/core_run_ctrl_pkg.sv
// Shared types and default parameters for the MIPS core run controller.
package core_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } run_state_t;

    localparam int DEF_PC_W        = 32;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_RST_CYCLES  = 1;
    localparam int DEF_MAX_CYCLES  = 10;
    localparam int DEF_HALT_REPEAT = 2;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Control and observation bundle between the run controller and its user.
interface core_run_ctrl_if
    import core_run_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic [PC_W-1:0]  pc;
    logic             mem_we;
    logic             reg_we;
    logic             core_rst;
    logic             run;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] branches;
    logic [CNT_W-1:0] stores;
    logic [CNT_W-1:0] writes;

    modport master (
        output start, pc, mem_we, reg_we,
        input  core_rst, run, done, timeout,
        input  cycles, branches, stores, writes
    );

    modport slave (
        input  start, pc, mem_we, reg_we,
        output core_rst, run, done, timeout,
        output cycles, branches, stores, writes
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] o_q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_q <= '0;
        end else if (clr) begin
            o_q <= '0;
        end else if (inc && (o_q != '1)) begin
            o_q <= o_q + W'(1);
        end
    end
endmodule

// File: rtl/core_run_ctrl.sv
// Start-triggered reset/run/halt sequencer with event counters for the core.
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
    input logic            clk,
    input logic            rst,
    core_run_ctrl_if.slave bus
);
    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int REP_W  = $clog2(HALT_REPEAT + 1);

    run_state_t      r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [REP_W-1:0]  r_rep;
    logic [PC_W-1:0]   r_prev_pc;
    logic              r_first;
    logic              r_core_rst;
    logic              r_run;
    logic              r_done;
    logic              r_timeout;

    logic              w_in_run;
    logic              w_clr;
    logic              w_same;
    logic              w_seq;
    logic              w_branch;
    logic [REP_W-1:0]  w_rep_nx;
    logic              w_halt;
    logic              w_budget;

    assign w_in_run = (r_state == S_RUN);
    assign w_clr    = bus.start && (r_state == S_IDLE ||
                                    r_state == S_DONE ||
                                    r_state == S_TIMEOUT);
    assign w_same   = (bus.pc == r_prev_pc);
    assign w_seq    = (bus.pc == r_prev_pc + PC_W'(4));
    assign w_branch = w_in_run && !r_first && !w_same && !w_seq;
    assign w_rep_nx = (r_first || !w_same) ? '0 : r_rep + REP_W'(1);
    assign w_halt   = (w_rep_nx == REP_W'(HALT_REPEAT));
    // Cycle counter still holds the pre-increment value this cycle.
    assign w_budget = (bus.cycles == CNT_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_rep      <= '0;
            r_prev_pc  <= '0;
            r_first    <= 1'b1;
            r_core_rst <= 1'b1;
            r_run      <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (bus.start) begin
                        r_state   <= S_HOLD;
                        r_hold    <= '0;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (r_hold == HOLD_W'(RST_CYCLES - 1)) begin
                        r_state    <= S_RUN;
                        r_core_rst <= 1'b0;
                        r_run      <= 1'b1;
                        r_first    <= 1'b1;
                        r_rep      <= '0;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    r_prev_pc <= bus.pc;
                    r_first   <= 1'b0;
                    r_rep     <= w_rep_nx;
                    if (w_halt) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_run      <= 1'b0;
                        r_core_rst <= 1'b1;
                    end else if (w_budget) begin
                        r_state    <= S_TIMEOUT;
                        r_timeout  <= 1'b1;
                        r_run      <= 1'b0;
                        r_core_rst <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk(clk), .rst(rst), .clr(w_clr),
        .inc(w_in_run), .o_q(bus.cycles)
    );
    sat_counter #(.W(CNT_W)) u_branches (
        .clk(clk), .rst(rst), .clr(w_clr),
        .inc(w_branch), .o_q(bus.branches)
    );
    sat_counter #(.W(CNT_W)) u_stores (
        .clk(clk), .rst(rst), .clr(w_clr),
        .inc(w_in_run && bus.mem_we), .o_q(bus.stores)
    );
    sat_counter #(.W(CNT_W)) u_writes (
        .clk(clk), .rst(rst), .clr(w_clr),
        .inc(w_in_run && bus.reg_we), .o_q(bus.writes)
    );

    assign bus.core_rst = r_core_rst;
    assign bus.run      = r_run;
    assign bus.done     = r_done;
    assign bus.timeout  = r_timeout;
endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Parametrised, synthesizable run controller for the single-cycle MIPS `core`. It replaces a fixed "hold reset, then clock N cycles" bench sequence with a start-triggered state machine. The machine holds the core in reset for a programmable time, runs it under a cycle budget, detects a self-loop halt, and counts execution events. It sits beside `core` and drives the core's active-high reset. It observes the core PC and write enables.

## Interface
- `PC_W`, 32: core PC width.
- `CNT_W`, 16: width of every event counter.
- `RST_CYCLES`, 1: cycles the core reset is held after start; must be ≥1.
- `MAX_CYCLES`, 10: run-cycle budget; must satisfy 1 ≤ MAX_CYCLES ≤ 2^CNT_W−1.
- `HALT_REPEAT`, 2: number of consecutive unchanged-PC cycles that counts as a halt; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `start` in 1: one-cycle request to (re)start a run.
- `pc` in PC_W: current core PC.
- `mem_we` in 1: core data-memory write enable.
- `reg_we` in 1: core register-file write enable.
- `core_rst` out 1: active-high reset to `core`.
- `run` out 1: core is executing.
- `done` out 1: halt detected (level).
- `timeout` out 1: budget exhausted without halt (level).
- `cycles`, `branches`, `stores`, `writes` out CNT_W each: event counters.

## Operation
- States: IDLE, HOLD, RUN, DONE, TIMEOUT.
- Reset values: state IDLE, `core_rst`=1, `run`=0, `done`=0, `timeout`=0, all counters 0.
- IDLE: `core_rst`=1. When `start`=1, go to HOLD; clear counters, flags and the hold counter.
- HOLD: `core_rst`=1 for exactly RST_CYCLES cycles, then go to RUN. `start` is ignored.
- RUN: `core_rst`=0, `run`=1. `start` is ignored. Each cycle:
  - `cycles`++.
  - `stores`++ if `mem_we`.
  - `writes`++ if `reg_we`.
  - From the second RUN cycle onward, `pc` is compared with `prev_pc`, the value registered in the previous cycle:
    - `pc`==`prev_pc`: repeat count ++, no branch counted.
    - `pc`≠`prev_pc` and `pc`≠`prev_pc`+4 (modulo 2^PC_W): `branches`++ and repeat count cleared.
    - Otherwise: repeat count cleared.
  - On the first RUN cycle no comparison is made; the repeat count stays 0.
- RUN exit:
  - Repeat count reaching HALT_REPEAT → DONE.
  - `cycles` reaching MAX_CYCLES → TIMEOUT.
  - Both in the same cycle → DONE wins.
  - Events from the exit cycle are included in the counters.
- DONE / TIMEOUT: `core_rst`=1, `run`=0, counters frozen, `done` or `timeout` held at 1. `start` → HOLD, which clears counters and both flags.
- All counters saturate at all-ones.

## Timing
- All outputs are registered. `core_rst` additionally asserts asynchronously on `rst` low.
- `start` sampled high at edge E:
  - HOLD covers the cycles following E through E+RST_CYCLES.
  - First RUN cycle (`core_rst`=0, `run`=1) begins at edge E+RST_CYCLES.
- Halt with HALT_REPEAT=2, PC sequence A,A,A: DONE is entered at the edge ending the third A cycle. `run` falls and `done` rises at that edge.
- No halt: TIMEOUT is entered at the edge ending RUN cycle MAX_CYCLES, with `cycles`=MAX_CYCLES.
- `rst` low at any time, including mid-HOLD or mid-RUN: all state returns to reset values immediately. After `rst` releases, the next `start` behaves as from IDLE.

## Structure
- Package `core_run_pkg`:
  - state enum `run_state_t`.
  - default-parameter constants.
- Sub-module `sat_counter` (param W; inputs `clr`, `inc`; saturating output).
  - Four instances: cycles, branches, stores, writes.
  - Hold counter and repeat counter are local to `core_run_ctrl`.

## Test plan
- `rst`=0 for 2 cycles → `core_rst`=1, `run`=0, `done`=`timeout`=0, all counters 0. No exit from IDLE without `start`.
- Defaults; `start` pulse; `pc`=0,4,8,… forever → `core_rst` high 1 cycle after start. Then `run` high exactly 10 cycles; `timeout`=1, `cycles`=10, `branches`=0.
- RUN `pc` sequence 0,4,8,0x20,0x24,0x24,0x24 → `done`=1 after 7th RUN cycle, `cycles`=7, `branches`=1, `timeout`=0.
- Same run with `mem_we` high on 2 cycles and `reg_we` high on 5 → `stores`=2, `writes`=5. A `start` pulse during RUN is ignored.
- From DONE, pulse `start` → counters and `done` clear. Repeat the sequence above → identical results.
- Drive `rst`=0 in RUN cycle 3 → `core_rst`=1 immediately, counters 0, IDLE. After release, a new `start` completes normally.
